// File: rtl/rename_pkg.sv
// Shared widths and types for the register rename stage.
// Defaults describe the 32-arch / 64-phys / 32-entry configuration.
package rename_pkg;

  localparam int NUM_ARCH_REGS_DEF = 32;
  localparam int NUM_PHYS_REGS_DEF = 64;
  localparam int AL_DEPTH_DEF      = 32;

  typedef logic [$clog2(NUM_ARCH_REGS_DEF)-1:0] MipsReg;
  typedef MipsReg                               ArchReg;
  typedef logic [$clog2(NUM_PHYS_REGS_DEF)-1:0] PhysReg;
  typedef logic [$clog2(AL_DEPTH_DEF)-1:0]      AlTag;

  typedef struct packed {
    logic   has_dest;
    ArchReg arch_rd;
    PhysReg new_phys;
    PhysReg old_phys;
  } ActiveListEntry;

endpackage

// File: rtl/phys_free_list.sv
// Speculative and committed physical-register free vectors.
// Allocation picks the lowest free register; flush restores the committed view.
module phys_free_list
  import rename_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  localparam int PW = $clog2(NUM_PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_en,
  output logic [PW-1:0] alloc_phys,
  output logic          free_any,
  input  logic          release_en,
  input  logic [PW-1:0] release_phys,
  input  logic [PW-1:0] retire_phys,
  input  logic          flush
);

  logic [NUM_PHYS_REGS-1:0] spec_free, spec_next;
  logic [NUM_PHYS_REGS-1:0] com_free, com_next;

  assign free_any = |spec_free;

  // Downward scan so the lowest set bit wins.
  always_comb begin
    alloc_phys = '0;
    for (int i = NUM_PHYS_REGS - 1; i >= 0; i--) begin
      if (spec_free[i]) alloc_phys = PW'(i);
    end
  end

  always_comb begin
    com_next = com_free;
    if (release_en) begin
      if (release_phys != '0) com_next[release_phys] = 1'b1;
      com_next[retire_phys] = 1'b0;
    end
    spec_next = spec_free;
    if (alloc_en) spec_next[alloc_phys] = 1'b0;
    if (release_en && release_phys != '0) spec_next[release_phys] = 1'b1;
    if (flush) spec_next = com_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        spec_free[i] <= (i >= NUM_ARCH_REGS);
        com_free[i]  <= (i >= NUM_ARCH_REGS);
      end
    end else begin
      spec_free <= spec_next;
      com_free  <= com_next;
    end
  end

endmodule

// File: rtl/reg_rename_unit.sv
// Rename stage: speculative/committed map tables, active-list ring and a
// one-deep output register between decode and the issue queue.
module reg_rename_unit
  import rename_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  parameter int AL_DEPTH      = AL_DEPTH_DEF,
  localparam int PW = $clog2(NUM_PHYS_REGS),
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int TW = $clog2(AL_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_uses_rs,
  input  logic          in_uses_rt,
  input  logic [AW-1:0] in_rs_addr,
  input  logic [AW-1:0] in_rt_addr,
  input  logic          in_uses_rw,
  input  logic [AW-1:0] in_rw_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_rs_phys,
  output logic [PW-1:0] out_rt_phys,
  output logic [PW-1:0] out_rd_phys,
  output logic [PW-1:0] out_old_phys,
  output logic [TW-1:0] out_al_tag,
  input  logic          commit_valid,
  input  logic          flush,
  output logic [TW:0]   al_count
);

  typedef struct packed {
    logic          has_dest;
    logic [AW-1:0] arch_rd;
    logic [PW-1:0] new_phys;
    logic [PW-1:0] old_phys;
  } al_entry_t;

  localparam logic [TW:0] AL_FULL = (TW+1)'(AL_DEPTH);

  logic [PW-1:0] rmt [NUM_ARCH_REGS];
  logic [PW-1:0] amt [NUM_ARCH_REGS];
  logic [PW-1:0] amt_next [NUM_ARCH_REGS];
  al_entry_t     al_mem [AL_DEPTH];
  logic [TW-1:0] head, tail;

  logic          allocating, accept, do_commit, commit_dest, free_any;
  logic [PW-1:0] alloc_phys;
  al_entry_t     head_entry, new_entry;

  assign allocating  = in_uses_rw && (in_rw_addr != '0);
  assign in_ready    = !flush && (!out_valid || out_ready) && (al_count < AL_FULL)
                       && (free_any || !allocating);
  assign accept      = in_valid && in_ready;
  assign do_commit   = commit_valid && (al_count != '0);
  assign head_entry  = al_mem[head];
  assign commit_dest = do_commit && head_entry.has_dest;

  assign new_entry.has_dest = allocating;
  assign new_entry.arch_rd  = in_rw_addr;
  assign new_entry.new_phys = allocating ? alloc_phys : '0;
  assign new_entry.old_phys = allocating ? rmt[in_rw_addr] : '0;

  phys_free_list #(
    .NUM_ARCH_REGS(NUM_ARCH_REGS),
    .NUM_PHYS_REGS(NUM_PHYS_REGS)
  ) u_free_list (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en     (accept && allocating),
    .alloc_phys   (alloc_phys),
    .free_any     (free_any),
    .release_en   (commit_dest),
    .release_phys (head_entry.old_phys),
    .retire_phys  (head_entry.new_phys),
    .flush        (flush)
  );

  // Committed map including this cycle's retirement; flush restores from it.
  always_comb begin
    amt_next = amt;
    if (commit_dest) amt_next[head_entry.arch_rd] = head_entry.new_phys;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rmt[i] <= PW'(i);
        amt[i] <= PW'(i);
      end
    end else begin
      amt <= amt_next;
      if (flush) rmt <= amt_next;
      else if (accept && allocating) rmt[in_rw_addr] <= alloc_phys;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) al_mem[tail] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      al_count <= '0;
    end else begin
      if (do_commit) head <= head + TW'(1);
      if (flush) begin
        tail     <= do_commit ? head + TW'(1) : head;
        al_count <= '0;
      end else begin
        if (accept) tail <= tail + TW'(1);
        al_count <= al_count + (TW+1)'(accept) - (TW+1)'(do_commit);
      end
    end
  end

  // Output stage: loads on accept, holds while the issue queue stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_rs_phys  <= '0;
      out_rt_phys  <= '0;
      out_rd_phys  <= '0;
      out_old_phys <= '0;
      out_al_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs_phys  <= in_uses_rs ? rmt[in_rs_addr] : '0;
      out_rt_phys  <= in_uses_rt ? rmt[in_rt_addr] : '0;
      out_rd_phys  <= new_entry.new_phys;
      out_old_phys <= new_entry.old_phys;
      out_al_tag   <= tail;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_rename_unit.sv
// Directed bench for reg_rename_unit with hand-computed expectations.
module tb_reg_rename_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_uses_rs, in_uses_rt, in_uses_rw;
  logic [4:0] in_rs_addr, in_rt_addr, in_rw_addr;
  logic       out_valid, out_ready;
  logic [5:0] out_rs_phys, out_rt_phys, out_rd_phys, out_old_phys;
  logic [4:0] out_al_tag;
  logic       commit_valid, flush;
  logic [5:0] al_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_rename_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_uses_rs   (in_uses_rs),
    .in_uses_rt   (in_uses_rt),
    .in_rs_addr   (in_rs_addr),
    .in_rt_addr   (in_rt_addr),
    .in_uses_rw   (in_uses_rw),
    .in_rw_addr   (in_rw_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs_phys  (out_rs_phys),
    .out_rt_phys  (out_rt_phys),
    .out_rd_phys  (out_rd_phys),
    .out_old_phys (out_old_phys),
    .out_al_tag   (out_al_tag),
    .commit_valid (commit_valid),
    .flush        (flush),
    .al_count     (al_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic urs, input logic [4:0] rs,
                           input logic urt, input logic [4:0] rt,
                           input logic urw, input logic [4:0] rw);
    in_valid   = v;
    in_uses_rs = urs;
    in_rs_addr = rs;
    in_uses_rt = urt;
    in_rt_addr = rt;
    in_uses_rw = urw;
    in_rw_addr = rw;
  endtask

  task automatic do_reset;
    rst_n        = 1'b0;
    out_ready    = 1'b1;
    commit_valid = 1'b0;
    flush        = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
    checks++; if (al_count !== 6'd0) begin errors++; $display("FAIL reset_al_count got %0d exp 0", al_count); end
    checks++; if (out_rd_phys !== 6'd0) begin errors++; $display("FAIL reset_rd_phys got %0d exp 0", out_rd_phys); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", in_ready); end
  endtask

  task automatic test_rename_basic;
    do_reset;
    set_instr(1, 1, 3, 0, 0, 1, 5);
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", out_valid); end
    checks++; if (out_rd_phys !== 6'd32) begin errors++; $display("FAIL basic_rd got %0d exp 32", out_rd_phys); end
    checks++; if (out_old_phys !== 6'd5) begin errors++; $display("FAIL basic_old got %0d exp 5", out_old_phys); end
    checks++; if (out_al_tag !== 5'd0) begin errors++; $display("FAIL basic_tag got %0d exp 0", out_al_tag); end
    checks++; if (al_count !== 6'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", al_count); end
    checks++; if (out_rs_phys !== 6'd3 || out_rt_phys !== 6'd0) begin errors++; $display("FAIL basic_src got %0d/%0d exp 3/0", out_rs_phys, out_rt_phys); end
    set_instr(1, 1, 5, 1, 3, 1, 5);
    tick;
    checks++; if (out_rs_phys !== 6'd32) begin errors++; $display("FAIL raw_rs got %0d exp 32", out_rs_phys); end
    checks++; if (out_rt_phys !== 6'd3) begin errors++; $display("FAIL raw_rt got %0d exp 3", out_rt_phys); end
    checks++; if (out_rd_phys !== 6'd33 || out_old_phys !== 6'd32) begin errors++; $display("FAIL waw_rd_old got %0d/%0d exp 33/32", out_rd_phys, out_old_phys); end
    checks++; if (out_al_tag !== 5'd1) begin errors++; $display("FAIL waw_tag got %0d exp 1", out_al_tag); end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    tick;
    checks++; if (out_valid !== 1'b0 || al_count !== 6'd2) begin errors++; $display("FAIL drain got valid %0d count %0d exp 0/2", out_valid, al_count); end
  endtask

  task automatic test_al_full;
    do_reset;
    for (int i = 0; i < 32; i++) begin
      set_instr(1, 0, 0, 0, 0, 1, 5'((i % 31) + 1));
      tick;
    end
    set_instr(1, 0, 0, 0, 0, 1, 5'd1);
    checks++; if (al_count !== 6'd32) begin errors++; $display("FAIL full_count got %0d exp 32", al_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0d exp 0", in_ready); end
    checks++; if (out_rd_phys !== 6'd63 || out_al_tag !== 5'd31) begin errors++; $display("FAIL full_last got rd %0d tag %0d exp 63/31", out_rd_phys, out_al_tag); end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b1;
    tick;
    commit_valid = 1'b0;
    checks++; if (al_count !== 6'd31) begin errors++; $display("FAIL full_commit_count got %0d exp 31", al_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_commit_ready got %0d exp 1", in_ready); end
    // Retiring the first rename of $1 released phys 1, now the lowest free.
    set_instr(1, 0, 0, 0, 0, 1, 5'd7);
    tick;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_rd_phys !== 6'd1 || out_old_phys !== 6'd38) begin errors++; $display("FAIL full_realloc got %0d/%0d exp 1/38", out_rd_phys, out_old_phys); end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 0, 0, 0, 0, 1, 5'd5);
      tick;
    end
    checks++; if (out_rd_phys !== 6'd34 || al_count !== 6'd3) begin errors++; $display("FAIL flush_pre got rd %0d count %0d exp 34/3", out_rd_phys, al_count); end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b1;
    tick;
    commit_valid = 1'b0;
    flush = 1'b1;
    set_instr(1, 0, 0, 0, 0, 1, 5'd9);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0d exp 0", in_ready); end
    tick;
    flush = 1'b0;
    checks++; if (al_count !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_state got count %0d valid %0d exp 0/0", al_count, out_valid); end
    // Committed free set after retiring the first $5 write: {5, 33..63}.
    set_instr(1, 1, 5'd5, 0, 0, 1, 5'd6);
    tick;
    checks++; if (out_rs_phys !== 6'd32) begin errors++; $display("FAIL flush_rmt got %0d exp 32", out_rs_phys); end
    checks++; if (out_rd_phys !== 6'd5 || out_old_phys !== 6'd6) begin errors++; $display("FAIL flush_alloc got %0d/%0d exp 5/6", out_rd_phys, out_old_phys); end
    checks++; if (out_al_tag !== 5'd1) begin errors++; $display("FAIL flush_tag got %0d exp 1", out_al_tag); end
    set_instr(1, 0, 0, 0, 0, 1, 5'd7);
    tick;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_rd_phys !== 6'd33) begin errors++; $display("FAIL flush_reclaim got %0d exp 33", out_rd_phys); end
  endtask

  task automatic test_zero_write;
    do_reset;
    set_instr(1, 1, 5'd0, 0, 0, 1, 5'd0);
    tick;
    checks++; if (out_rd_phys !== 6'd0 || out_old_phys !== 6'd0) begin errors++; $display("FAIL zero_rd_old got %0d/%0d exp 0/0", out_rd_phys, out_old_phys); end
    checks++; if (al_count !== 6'd1 || out_rs_phys !== 6'd0) begin errors++; $display("FAIL zero_count_rs got %0d/%0d exp 1/0", al_count, out_rs_phys); end
    set_instr(1, 0, 0, 0, 0, 1, 5'd5);
    tick;
    checks++; if (out_rd_phys !== 6'd32) begin errors++; $display("FAIL zero_nofree got %0d exp 32", out_rd_phys); end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    commit_valid = 1'b1;
    tick;
    tick;
    commit_valid = 1'b0;
    checks++; if (al_count !== 6'd0) begin errors++; $display("FAIL zero_commit_count got %0d exp 0", al_count); end
    set_instr(1, 0, 0, 0, 0, 1, 5'd6);
    tick;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_rd_phys !== 6'd5) begin errors++; $display("FAIL zero_commit_frees got %0d exp 5", out_rd_phys); end
    // Commit with an empty active list is ignored.
    commit_valid = 1'b1;
    tick;
    tick;
    commit_valid = 1'b0;
    checks++; if (al_count !== 6'd0) begin errors++; $display("FAIL empty_commit got %0d exp 0", al_count); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    out_ready = 1'b0;
    set_instr(1, 0, 0, 0, 0, 1, 5'd5);
    tick;
    set_instr(1, 0, 0, 0, 0, 1, 5'd6);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0d exp 0", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_rd_phys !== 6'd32 || al_count !== 6'd1) begin errors++; $display("FAIL stall_hold got v%0d rd %0d cnt %0d exp 1/32/1", out_valid, out_rd_phys, al_count); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %0d exp 1", in_ready); end
    tick;
    checks++; if (out_rd_phys !== 6'd33 || out_old_phys !== 6'd6 || out_al_tag !== 5'd1) begin errors++; $display("FAIL stall_next got %0d/%0d/%0d exp 33/6/1", out_rd_phys, out_old_phys, out_al_tag); end
    set_instr(1, 0, 0, 0, 0, 1, 5'd7);
    commit_valid = 1'b1;
    tick;
    commit_valid = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    checks++; if (al_count !== 6'd2) begin errors++; $display("FAIL same_cycle_count got %0d exp 2", al_count); end
    checks++; if (out_rd_phys !== 6'd34 || out_al_tag !== 5'd2) begin errors++; $display("FAIL same_cycle_rd got %0d/%0d exp 34/2", out_rd_phys, out_al_tag); end
  endtask

  task automatic test_async_reset;
    do_reset;
    set_instr(1, 0, 0, 0, 0, 1, 5'd5);
    tick;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || al_count !== 6'd0 || out_rd_phys !== 6'd0) begin errors++; $display("FAIL async_reset got v%0d cnt %0d rd %0d exp 0/0/0", out_valid, al_count, out_rd_phys); end
    tick;
    rst_n = 1'b1;
    set_instr(1, 0, 0, 0, 0, 1, 5'd5);
    tick;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_rd_phys !== 6'd32 || out_al_tag !== 5'd0) begin errors++; $display("FAIL async_restart got %0d/%0d exp 32/0", out_rd_phys, out_al_tag); end
  endtask

  initial begin
    test_reset;
    test_rename_basic;
    test_al_full;
    test_flush;
    test_zero_write;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
